uart_tx: RTL and testbench

- 8N1 UART serializer directly downstream of the bridge transmit formatter.
- Consumes one byte per start/done handshake and drives the physical TX pin.
- Supports back-to-back bytes while `start_i` is held high, so the formatter can stream a multi-byte response message without gaps beyond one clock.

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 78 +++++++
 tb/tb_uart_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and serial line between the transmit formatter and the serializer
interface uart_tx_if;
    logic [7:0] data_i;
    logic       start_i;
    logic       done_o;
    logic       busy_o;
    logic       tx;
    modport master (output data_i, start_i, input done_o, busy_o, tx);
    modport slave  (input data_i, start_i, output done_o, busy_o, tx);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART serializer; one byte per start/done handshake, registered idle-high TX line
module uart_tx #(
    parameter int CLOCKS_PER_BAUD = 104
) (
    input logic      clk,
    input logic      rst,
    uart_tx_if.slave bus
);
    localparam int CW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_last;
    assign w_last     = r_cnt == LAST;
    assign bus.tx     = r_tx;
    assign bus.busy_o = r_state != S_IDLE;
    assign bus.done_o = (r_state == S_STOP) && w_last;
    // Frame sequencer: TX level is computed one cycle ahead so the line itself is a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_shift <= bus.data_i;
                        r_cnt   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_tx  <= r_shift[r_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of the 8N1 serializer at 4 and 2 clocks per baud
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_q[$];
    logic prev_done = 1'b0;
    logic dbl = 1'b0;

    uart_tx_if if4();
    uart_tx_if if2();

    uart_tx #(.CLOCKS_PER_BAUD(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    uart_tx #(.CLOCKS_PER_BAUD(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every done pulse of the 4-clock instance with its cycle number
    always @(negedge clk) begin
        if (if4.done_o) done_q.push_back(cyc);
        if (if4.done_o && prev_done) dbl <= 1'b1;
        prev_done <= if4.done_o;
    end

    // Receiver: samples one frame starting the cycle after the accepting edge
    task automatic capture(input int cpb, input bit use2, input bit pulse,
                           output logic [9:0] fr, output bit gl, output int nd, output int da);
        logic lv;
        fr = '0; gl = 1'b0; nd = 0; da = 0;
        for (int k = 1; k <= 10 * cpb; k++) begin
            @(negedge clk);
            if (pulse && k == 1) begin
                if (use2) if2.start_i = 1'b0;
                else      if4.start_i = 1'b0;
            end
            lv = use2 ? if2.tx : if4.tx;
            if ((k - 1) % cpb == 0) fr[(k - 1) / cpb] = lv;
            else if (lv !== fr[(k - 1) / cpb]) gl = 1'b1;
            if (use2 ? if2.done_o : if4.done_o) begin
                nd++;
                da = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if4.start_i = 1'b1;
        if4.data_i = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (if4.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", if4.tx); end
            n_chk++; if (if4.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if4.done_o); end
            n_chk++; if (if4.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if4.busy_o); end
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (if4.busy_o !== 1'b1 || if4.tx !== 1'b0) begin n_fail++; $display("FAIL release_start: busy=%b tx=%b want busy=1 tx=0", if4.busy_o, if4.tx); end
        if4.start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [9:0] fr; bit gl; int nd, da;
        if4.data_i = 8'h44;
        if4.start_i = 1'b1;
        capture(4, 1'b0, 1'b1, fr, gl, nd, da);
        n_chk++; if (fr !== 10'b1_01000100_0) begin n_fail++; $display("FAIL single_frame: got %b want %b", fr, 10'b1_01000100_0); end
        n_chk++; if (gl !== 1'b0) begin n_fail++; $display("FAIL single_bitwidth: got glitch=%b want 0", gl); end
        n_chk++; if (nd !== 1 || da !== 40) begin n_fail++; $display("FAIL single_done: got count=%0d cycle=%0d want 1 at 40", nd, da); end
        @(negedge clk);
        n_chk++; if (if4.busy_o !== 1'b0 || if4.tx !== 1'b1 || if4.done_o !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b tx=%b done=%b want 0 1 0", if4.busy_o, if4.tx, if4.done_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [4] = '{8'h44, 8'h31, 8'h0D, 8'h0A};
        logic [9:0] exp [4] = '{10'b1_01000100_0, 10'b1_00110001_0, 10'b1_00001101_0, 10'b1_00001010_0};
        logic [9:0] fr; bit gl; int nd, da;
        done_q.delete();
        if4.data_i = msg[0];
        if4.start_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            capture(4, 1'b0, 1'b0, fr, gl, nd, da);
            n_chk++; if (fr !== exp[i] || gl !== 1'b0) begin n_fail++; $display("FAIL b2b_frame%0d: got %b glitch=%b want %b", i, fr, gl, exp[i]); end
            n_chk++; if (nd !== 1 || da !== 40) begin n_fail++; $display("FAIL b2b_done%0d: got count=%0d cycle=%0d want 1 at 40", i, nd, da); end
            if (i < 3) if4.data_i = msg[i + 1];
            else       if4.start_i = 1'b0;
            @(negedge clk);
            n_chk++; if (if4.tx !== 1'b1 || if4.busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gap%0d: tx=%b busy=%b want 1 0", i, if4.tx, if4.busy_o); end
        end
        repeat (8) @(negedge clk);
        n_chk++; if (done_q.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", done_q.size()); end
        if (done_q.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                n_chk++; if (done_q[i] - done_q[i - 1] !== 41) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 41", i, done_q[i] - done_q[i - 1]); end
            end
        end
        n_chk++; if (dbl !== 1'b0) begin n_fail++; $display("FAIL b2b_double_done: got %b want 0", dbl); end
    endtask

    task automatic test_stability();
        logic [9:0] fr; bit gl; int nd, da, n0; bit any_busy;
        n0 = done_q.size();
        if4.data_i = 8'hA5;
        if4.start_i = 1'b1;
        fork
            capture(4, 1'b0, 1'b1, fr, gl, nd, da);
            begin
                repeat (14) @(negedge clk);
                if4.data_i = 8'h5A;
                repeat (6) @(negedge clk);
                if4.start_i = 1'b1;
                repeat (4) @(negedge clk);
                if4.start_i = 1'b0;
            end
        join
        n_chk++; if (fr !== 10'b1_10100101_0 || gl !== 1'b0) begin n_fail++; $display("FAIL stable_frame: got %b glitch=%b want %b", fr, gl, 10'b1_10100101_0); end
        n_chk++; if (nd !== 1 || da !== 40) begin n_fail++; $display("FAIL stable_done: got count=%0d cycle=%0d want 1 at 40", nd, da); end
        any_busy = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (if4.busy_o !== 1'b0) any_busy = 1'b1;
        end
        n_chk++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL stable_no_extra_frame: busy seen=%b want 0", any_busy); end
        n_chk++; if (done_q.size() !== n0 + 1) begin n_fail++; $display("FAIL stable_done_total: got %0d want %0d", done_q.size(), n0 + 1); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr; bit gl; int nd, da, n0;
        n0 = done_q.size();
        if4.data_i = 8'h00;
        if4.start_i = 1'b1;
        @(negedge clk);
        if4.start_i = 1'b0;
        repeat (17) @(negedge clk);
        n_chk++; if (if4.tx !== 1'b0 || if4.busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_pre: tx=%b busy=%b want 0 1", if4.tx, if4.busy_o); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (if4.tx !== 1'b1 || if4.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_async: tx=%b busy=%b want 1 0", if4.tx, if4.busy_o); end
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        n_chk++; if (done_q.size() !== n0 || if4.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: dones=%0d busy=%b want %0d 0", done_q.size(), if4.busy_o, n0); end
        if4.data_i = 8'h7E;
        if4.start_i = 1'b1;
        capture(4, 1'b0, 1'b1, fr, gl, nd, da);
        n_chk++; if (fr !== 10'b1_01111110_0 || gl !== 1'b0) begin n_fail++; $display("FAIL abort_next_frame: got %b glitch=%b want %b", fr, gl, 10'b1_01111110_0); end
        n_chk++; if (nd !== 1 || da !== 40) begin n_fail++; $display("FAIL abort_next_done: got count=%0d cycle=%0d want 1 at 40", nd, da); end
        @(negedge clk);
    endtask

    task automatic test_min_baud();
        logic [9:0] fr; bit gl; int nd, da;
        if2.data_i = 8'h55;
        if2.start_i = 1'b1;
        capture(2, 1'b1, 1'b1, fr, gl, nd, da);
        n_chk++; if (fr !== 10'b1_01010101_0 || gl !== 1'b0) begin n_fail++; $display("FAIL min_frame: got %b glitch=%b want %b", fr, gl, 10'b1_01010101_0); end
        n_chk++; if (nd !== 1 || da !== 20) begin n_fail++; $display("FAIL min_done: got count=%0d cycle=%0d want 1 at 20", nd, da); end
        @(negedge clk);
        n_chk++; if (if2.busy_o !== 1'b0 || if2.tx !== 1'b1) begin n_fail++; $display("FAIL min_idle: busy=%b tx=%b want 0 1", if2.busy_o, if2.tx); end
    endtask

    initial begin
        if4.start_i = 1'b0;
        if4.data_i = 8'h00;
        if2.start_i = 1'b0;
        if2.data_i = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_stability();
        test_reset_mid();
        test_min_baud();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
